// File: rtl/alu_pkg.sv
// Shared definitions for the subtractor result stage: skid-buffer state
// encoding and the width of the payload carried alongside each difference.
package alu_pkg;

    // Number of entries currently held by the 2-entry skid buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // Flags stored next to the data: zero, neg, borrow.
    localparam int FLAG_BITS = 3;

    // Payload width for a given data width: {borrow, neg, zero, data}.
    function automatic int payload_w(input int width);
        return width + FLAG_BITS;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. in_ready and out_valid are both
// registered; the head register drives out_data directly, and the skid
// register catches the one beat that may arrive while the head is stalled.
module alu_skid_buf
    import alu_pkg::*;
#(
    parameter int DW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    skid_state_e   state_r;
    logic          ready_r;
    logic          valid_r;
    logic [DW-1:0] head_r;
    logic [DW-1:0] skid_r;
    logic          accept_s;
    logic          emit_s;

    assign accept_s  = in_valid & ready_r;
    assign emit_s    = valid_r & out_ready;
    assign in_ready  = ready_r;
    assign out_valid = valid_r;
    assign out_data  = head_r;

    // Occupancy FSM with registered ready/valid and the two data slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            head_r  <= {DW{1'b0}};
            skid_r  <= {DW{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        head_r  <= in_data;
                        state_r <= ST_ONE;
                        valid_r <= 1'b1;
                        ready_r <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept_s && !emit_s) begin
                        // Head is stalled: park the new beat in the skid slot.
                        skid_r  <= in_data;
                        state_r <= ST_FULL;
                        ready_r <= 1'b0;
                    end else if (emit_s && !accept_s) begin
                        state_r <= ST_EMPTY;
                        valid_r <= 1'b0;
                    end else if (accept_s && emit_s) begin
                        // Head leaves and the new beat takes its place.
                        head_r  <= in_data;
                    end else begin
                        head_r  <= head_r;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only an emit can happen.
                    if (emit_s) begin
                        head_r  <= skid_r;
                        state_r <= ST_ONE;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sub_result_stage.sv
// Registered output stage behind the n-bit subtractor. Derives zero/neg
// flags at accept time, buffers {borrow,neg,zero,diff} in a 2-entry skid
// buffer, and keeps a sticky borrow flag plus a saturating borrow counter.
module sub_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_diff,
    input  logic             in_borrow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_borrow,
    input  logic             clr_sticky,
    output logic             sticky_borrow,
    output logic [CNT_W-1:0] borrow_cnt
);

    localparam int PW = payload_w(WIDTH);

    logic [PW-1:0]    in_payload_s;
    logic [PW-1:0]    out_payload_s;
    logic             zero_s;
    logic             accept_s;
    logic             borrow_evt_s;
    logic             sticky_r;
    logic [CNT_W-1:0] cnt_r;

    assign zero_s       = (in_diff == {WIDTH{1'b0}});
    assign in_payload_s = {in_borrow, in_diff[WIDTH-1], zero_s, in_diff};
    assign accept_s     = in_valid & in_ready;
    assign borrow_evt_s = accept_s & in_borrow;

    alu_skid_buf #(
        .DW (PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload_s)
    );

    assign out_data      = out_payload_s[WIDTH-1:0];
    assign out_zero      = out_payload_s[WIDTH];
    assign out_neg       = out_payload_s[WIDTH+1];
    assign out_borrow    = out_payload_s[WIDTH+2];
    assign sticky_borrow = sticky_r;
    assign borrow_cnt    = cnt_r;

    // Sticky borrow: a new borrow event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= 1'b0;
        end else if (borrow_evt_s) begin
            sticky_r <= 1'b1;
        end else if (clr_sticky) begin
            sticky_r <= 1'b0;
        end else begin
            sticky_r <= sticky_r;
        end
    end

    // Borrow-event counter that saturates at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (borrow_evt_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_sub_result_stage.sv
// Directed + randomized-handshake bench for sub_result_stage (WIDTH=8, CNT_W=8).
module tb_sub_result_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_diff;
    logic       in_borrow;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_zero;
    logic       out_neg;
    logic       out_borrow;
    logic       clr_sticky;
    logic       sticky_borrow;
    logic [7:0] borrow_cnt;

    int checks = 0;
    int errors = 0;

    sub_result_stage #(
        .WIDTH (8),
        .CNT_W (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_diff       (in_diff),
        .in_borrow     (in_borrow),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_zero      (out_zero),
        .out_neg       (out_neg),
        .out_borrow    (out_borrow),
        .clr_sticky    (clr_sticky),
        .sticky_borrow (sticky_borrow),
        .borrow_cnt    (borrow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({out_valid, in_ready, out_data, out_zero, out_neg, out_borrow, sticky_borrow, borrow_cnt}
            !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: got valid=%b ready=%b data=%h z=%b n=%b b=%b st=%b cnt=%h, want 0 1 00 0 0 0 0 00",
                     out_valid, in_ready, out_data, out_zero, out_neg, out_borrow, sticky_borrow, borrow_cnt);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Fill the buffer, then assert reset asynchronously mid-stream.
    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_diff = 8'h10; in_borrow = 1'b1;
        step();
        in_diff = 8'h20;
        step();
        in_valid = 1'b0; in_borrow = 1'b0;
        checks++;
        if ({in_ready, out_valid, borrow_cnt} !== {1'b0, 1'b1, 8'h02}) begin
            errors++;
            $display("FAIL full_before_reset: got ready=%b valid=%b cnt=%h, want 0 1 02", in_ready, out_valid, borrow_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, borrow_cnt, sticky_borrow} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got valid=%b ready=%b cnt=%h st=%b, want 0 1 00 0", out_valid, in_ready, borrow_cnt, sticky_borrow);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({out_valid, in_ready, borrow_cnt} !== {1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL after_reset: got valid=%b ready=%b cnt=%h, want 0 1 00", out_valid, in_ready, borrow_cnt);
        end
    endtask

    // Streaming with out_ready=1: one-cycle latency and no bubbles.
    task automatic test_stream();
        logic [7:0] vals [3];
        logic [1:0] flags [3];
        vals[0] = 8'h00; flags[0] = 2'b10;
        vals[1] = 8'h05; flags[1] = 2'b00;
        vals[2] = 8'h80; flags[2] = 2'b01;
        out_ready = 1'b1;
        in_borrow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_diff  = vals[i];
            step();
            checks++;
            if ({out_valid, in_ready, out_data, out_zero, out_neg} !== {1'b1, 1'b1, vals[i], flags[i]}) begin
                errors++;
                $display("FAIL stream_%0d: got valid=%b ready=%b data=%h z=%b n=%b, want 1 1 %h %b",
                         i, out_valid, in_ready, out_data, out_zero, out_neg, vals[i], flags[i]);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: got valid=%b, want 0", out_valid);
        end
    endtask

    // Back-pressure: in_ready drops after two accepts, order preserved on release.
    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_diff = 8'h11;
        step();
        checks++;
        if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 8'h11}) begin
            errors++;
            $display("FAIL bp_first: got ready=%b valid=%b data=%h, want 1 1 11", in_ready, out_valid, out_data);
        end
        in_diff = 8'h22;
        step();
        checks++;
        if ({in_ready, out_data} !== {1'b0, 8'h11}) begin
            errors++;
            $display("FAIL bp_full: got ready=%b data=%h, want 0 11", in_ready, out_data);
        end
        in_diff = 8'h33;
        step();
        checks++;
        if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 8'h11}) begin
            errors++;
            $display("FAIL bp_hold: got ready=%b valid=%b data=%h, want 0 1 11", in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 8'h22}) begin
            errors++;
            $display("FAIL bp_rel1: got ready=%b valid=%b data=%h, want 1 1 22", in_ready, out_valid, out_data);
        end
        step();
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'h33}) begin
            errors++;
            $display("FAIL bp_rel2: got valid=%b data=%h, want 1 33", out_valid, out_data);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got valid=%b, want 0", out_valid);
        end
    endtask

    // Sticky flag: set beats a same-cycle clear; a later clear resets it.
    task automatic test_sticky();
        out_ready  = 1'b1;
        in_valid   = 1'b1; in_diff = 8'hF0; in_borrow = 1'b1;
        clr_sticky = 1'b1;
        step();
        checks++;
        if ({sticky_borrow, out_borrow, borrow_cnt} !== {1'b1, 1'b1, 8'h01}) begin
            errors++;
            $display("FAIL sticky_set_wins: got st=%b b=%b cnt=%h, want 1 1 01", sticky_borrow, out_borrow, borrow_cnt);
        end
        in_valid = 1'b0; in_borrow = 1'b0;
        step();
        clr_sticky = 1'b0;
        checks++;
        if ({sticky_borrow, borrow_cnt} !== {1'b0, 8'h01}) begin
            errors++;
            $display("FAIL sticky_clear: got st=%b cnt=%h, want 0 01", sticky_borrow, borrow_cnt);
        end
    endtask

    // in_valid with borrow while FULL must not touch counter or sticky.
    task automatic test_full_ignore();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_borrow = 1'b0; in_diff = 8'h01;
        step();
        in_diff = 8'h02;
        step();
        in_diff = 8'h03; in_borrow = 1'b1;
        step();
        step();
        checks++;
        if ({in_ready, sticky_borrow, borrow_cnt, out_data} !== {1'b0, 1'b0, 8'h01, 8'h01}) begin
            errors++;
            $display("FAIL full_ignore: got ready=%b st=%b cnt=%h data=%h, want 0 0 01 01", in_ready, sticky_borrow, borrow_cnt, out_data);
        end
        in_valid = 1'b0; in_borrow = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, out_data, out_borrow} !== {1'b1, 8'h02, 1'b0}) begin
            errors++;
            $display("FAIL full_drain: got valid=%b data=%h b=%b, want 1 02 0", out_valid, out_data, out_borrow);
        end
        step();
    endtask

    // 300 borrow accepts: counter tracks the model and stops at 0xFF.
    task automatic test_saturate();
        int exp_cnt;
        exp_cnt = 1;
        out_ready = 1'b1;
        in_valid  = 1'b1; in_borrow = 1'b1; in_diff = 8'hAA;
        for (int i = 0; i < 300; i++) begin
            if (in_ready && exp_cnt < 255) exp_cnt++;
            step();
            checks++;
            if (borrow_cnt !== 8'(exp_cnt)) begin
                errors++;
                $display("FAIL sat_cnt_%0d: got cnt=%h, want %h", i, borrow_cnt, 8'(exp_cnt));
            end
        end
        in_valid = 1'b0; in_borrow = 1'b0;
        step();
        checks++;
        if (borrow_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL sat_final: got cnt=%h, want ff", borrow_cnt);
        end
    endtask

    // Random valid/ready over 1000 items, checked against a FIFO scoreboard.
    task automatic test_random();
        logic [10:0] q[$];
        logic [10:0] got;
        logic [10:0] exp;
        logic [7:0]  d;
        logic        acc;
        logic        emi;
        int sent = 0;
        int recvd = 0;
        int cyc = 0;
        while (recvd < 1000 && cyc < 20000) begin
            d         = 8'(sent * 37);
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_diff   = d;
            in_borrow = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            acc = in_valid && in_ready;
            emi = out_valid && out_ready;
            if (emi) begin
                got = {out_borrow, out_neg, out_zero, out_data};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra: got %h with empty scoreboard", got);
                end else begin
                    exp = q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL rnd_item_%0d: got %h, want %h", recvd, got, exp);
                    end
                end
                recvd++;
            end
            if (acc) begin
                q.push_back({in_borrow, d[7], (d == 8'h00), d});
                sent++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (recvd !== 1000 || q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rnd_complete: got recvd=%0d left=%0d valid=%b, want 1000 0 0", recvd, q.size(), out_valid);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_diff    = 8'h00;
        in_borrow  = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        #12;
        test_reset();
        test_reset_full();
        test_stream();
        test_backpressure();
        test_sticky();
        test_full_ignore();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
